// File: rtl/zkey_event.sv
// Turns debounced button levels into PRESS/LONG/REPEAT/RELEASE events for one key at a time.
// Events wait in a registered valid/ack slot; a new event that finds the slot occupied is dropped.
module zkey_event #(
    parameter int CNT_W         = 26,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] iButton,
    input  logic       iEvtAck,
    output logic       oEvtValid,
    output logic [1:0] oEvtKey,
    output logic [1:0] oEvtType,
    output logic       oDrop,
    output logic [1:0] dbg_state
);

    // Handshake: an event is offered while oEvtValid is high, and it is consumed
    // on a rising edge where oEvtValid and iEvtAck are both high.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        RPT      = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_LONG    = 2'd1;
    localparam logic [1:0] EVT_REPEAT  = 2'd2;
    localparam logic [1:0] EVT_RELEASE = 2'd3;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [1:0]       key, key_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       low_idx;
    logic             gen;
    logic [1:0]       gen_type;
    logic [1:0]       gen_key;

    assign dbg_state = state;

    // Lowest pressed button wins when several go down together.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (iButton[i]) low_idx = 2'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key;
        cnt_nxt   = cnt;
        gen       = 1'b0;
        gen_type  = EVT_PRESS;
        gen_key   = key;
        if (!en) begin
            state_nxt = WAIT_REL;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|iButton) begin
                        key_nxt   = low_idx;
                        gen       = 1'b1;
                        gen_key   = low_idx;
                        gen_type  = EVT_PRESS;
                        cnt_nxt   = '0;
                        state_nxt = HELD;
                    end
                end
                HELD, RPT: begin
                    if (!iButton[key]) begin
                        gen       = 1'b1;
                        gen_type  = EVT_RELEASE;
                        cnt_nxt   = '0;
                        state_nxt = (|iButton) ? WAIT_REL : IDLE;
                    end else if (state == HELD && cnt == LONG_LAST) begin
                        gen       = 1'b1;
                        gen_type  = EVT_LONG;
                        cnt_nxt   = '0;
                        state_nxt = RPT;
                    end else if (state == RPT && cnt == REPEAT_LAST) begin
                        gen      = 1'b1;
                        gen_type = EVT_REPEAT;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (iButton == 4'd0) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = WAIT_REL;
            endcase
        end
    end

    // Reset lands in WAIT_REL so a key held through reset stays silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_REL;
            key   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            key   <= key_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oEvtValid <= 1'b0;
            oEvtKey   <= 2'd0;
            oEvtType  <= 2'd0;
            oDrop     <= 1'b0;
        end else begin
            oDrop <= 1'b0;
            if (gen) begin
                if (oEvtValid && !iEvtAck) begin
                    oDrop <= 1'b1;
                end else begin
                    oEvtValid <= 1'b1;
                    oEvtKey   <= gen_key;
                    oEvtType  <= gen_type;
                end
            end else if (oEvtValid && iEvtAck) begin
                oEvtValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zkey_event.sv
// Bench for zkey_event: directed scenarios with literal expectations plus random traffic
// checked every cycle against a press-age based event model.
module tb_zkey_event;

    localparam int LONG_N = 8;
    localparam int REP_N  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [3:0] iButton = 4'd0;
    logic       iEvtAck = 1'b1;
    logic       oEvtValid;
    logic [1:0] oEvtKey;
    logic [1:0] oEvtType;
    logic       oDrop;
    logic [1:0] dbg_state;

    int checks = 0;
    int failures = 0;

    zkey_event #(
        .CNT_W(26),
        .LONG_CYCLES(LONG_N),
        .REPEAT_CYCLES(REP_N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .iButton(iButton),
        .iEvtAck(iEvtAck),
        .oEvtValid(oEvtValid),
        .oEvtKey(oEvtKey),
        .oEvtType(oEvtType),
        .oDrop(oDrop),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Model: a tracked key has an age in cycles since its PRESS; LONG fires at age
    // LONG_N, REPEAT every REP_N cycles after that. 'armed' means all buttons
    // have read zero since the last release/reset/disable.
    logic       m_active = 1'b0;
    logic       m_armed = 1'b0;
    logic [1:0] m_key = 2'd0;
    int         m_age = 0;
    logic       m_valid = 1'b0;
    logic [1:0] m_ekey = 2'd0;
    logic [1:0] m_type = 2'd0;
    logic       m_drop = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic       g;
        logic [1:0] gt;
        if (!rst_n) begin
            m_active = 1'b0;
            m_armed  = 1'b0;
            m_key    = 2'd0;
            m_age    = 0;
            m_valid  = 1'b0;
            m_ekey   = 2'd0;
            m_type   = 2'd0;
            m_drop   = 1'b0;
        end else begin
            g  = 1'b0;
            gt = 2'd0;
            if (!en) begin
                m_active = 1'b0;
                m_armed  = 1'b0;
            end else if (m_active) begin
                if (!iButton[m_key]) begin
                    g = 1'b1; gt = 2'd3;
                    m_active = 1'b0;
                    m_armed  = (iButton == 4'd0);
                end else begin
                    m_age = m_age + 1;
                    if (m_age == LONG_N) begin
                        g = 1'b1; gt = 2'd1;
                    end else if (m_age > LONG_N && (m_age - LONG_N) % REP_N == 0) begin
                        g = 1'b1; gt = 2'd2;
                    end
                end
            end else if (m_armed) begin
                if (iButton != 4'd0) begin
                    for (int i = 3; i >= 0; i--) if (iButton[i]) m_key = 2'(i);
                    m_active = 1'b1;
                    m_age    = 0;
                    g = 1'b1; gt = 2'd0;
                end
            end else if (iButton == 4'd0) begin
                m_armed = 1'b1;
            end
            m_drop = 1'b0;
            if (g) begin
                if (m_valid && !iEvtAck) begin
                    m_drop = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_ekey  = m_key;
                    m_type  = gt;
                end
            end else if (m_valid && iEvtAck) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare process: outputs are registered, so check mid-cycle on every cycle.
    always @(negedge clk) begin
        logic [5:0] act, exp;
        act = {oEvtValid, oEvtKey, oEvtType, oDrop};
        exp = {m_valid, m_ekey, m_type, m_drop};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model_cmp t=%0t {valid,key,type,drop} got=%b exp=%b", $time, act, exp);
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] b, input logic e, input logic a);
        iButton = b;
        en      = e;
        iEvtAck = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_evt(input string name, input int v, input int k, input int t);
        check_lit({name, "_valid"}, int'(oEvtValid), v);
        if (v != 0) begin
            check_lit({name, "_key"}, int'(oEvtKey), k);
            check_lit({name, "_type"}, int'(oEvtType), t);
        end
    endtask

    initial begin
        logic [3:0] b_cur;
        repeat (3) @(negedge clk);
        check_evt("reset", 0, 0, 0);
        check_lit("reset_drop", int'(oDrop), 0);
        rst_n = 1'b1;
        cyc(4'd0, 1'b1, 1'b1);

        // short tap on bit 0
        cyc(4'b0001, 1'b1, 1'b1);
        check_evt("tap_press", 1, 0, 0);
        cyc(4'b0001, 1'b1, 1'b1);
        check_evt("tap_ack_clears", 0, 0, 0);
        cyc(4'b0001, 1'b1, 1'b1);
        cyc(4'b0000, 1'b1, 1'b1);
        check_evt("tap_release", 1, 0, 3);
        cyc(4'b0000, 1'b1, 1'b1);

        // long hold on bit 2: LONG at +8, REPEAT at +4 and +8 after LONG
        cyc(4'b0100, 1'b1, 1'b1);
        check_evt("hold_press", 1, 2, 0);
        for (int i = 1; i < LONG_N; i++) cyc(4'b0100, 1'b1, 1'b1);
        check_evt("hold_before_long", 0, 0, 0);
        cyc(4'b0100, 1'b1, 1'b1);
        check_evt("hold_long", 1, 2, 1);
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i < REP_N; i++) cyc(4'b0100, 1'b1, 1'b1);
            check_evt("hold_before_rep", 0, 0, 0);
            cyc(4'b0100, 1'b1, 1'b1);
            check_evt("hold_repeat", 1, 2, 2);
        end
        cyc(4'b0000, 1'b1, 1'b1);
        check_evt("hold_release", 1, 2, 3);
        cyc(4'b0000, 1'b1, 1'b1);

        // two keys together: lowest tracked, other ignored until all released
        cyc(4'b0110, 1'b1, 1'b1);
        check_evt("dual_press", 1, 1, 0);
        cyc(4'b0100, 1'b1, 1'b1);
        check_evt("dual_release", 1, 1, 3);
        repeat (3) cyc(4'b0100, 1'b1, 1'b1);
        check_evt("dual_silent", 0, 0, 0);
        cyc(4'b0000, 1'b1, 1'b1);
        cyc(4'b0100, 1'b1, 1'b1);
        check_evt("dual_repress", 1, 2, 0);
        cyc(4'b0000, 1'b1, 1'b1);
        cyc(4'b0000, 1'b1, 1'b1);

        // no ack: RELEASE dropped with one pulse, PRESS held
        cyc(4'b1000, 1'b1, 1'b0);
        check_evt("noack_press", 1, 3, 0);
        cyc(4'b1000, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);
        check_evt("noack_held", 1, 3, 0);
        check_lit("noack_drop", int'(oDrop), 1);
        cyc(4'b0000, 1'b1, 1'b0);
        check_lit("noack_drop_once", int'(oDrop), 0);
        check_evt("noack_still", 1, 3, 0);
        cyc(4'b0000, 1'b1, 1'b1);
        check_evt("noack_acked", 0, 0, 0);

        // disable mid-hold: no RELEASE, no PRESS until fresh press
        cyc(4'b0001, 1'b1, 1'b1);
        check_evt("en_press", 1, 0, 0);
        cyc(4'b0001, 1'b0, 1'b1);
        check_evt("en_off", 0, 0, 0);
        repeat (3) cyc(4'b0001, 1'b1, 1'b1);
        check_evt("en_back_silent", 0, 0, 0);
        cyc(4'b0000, 1'b1, 1'b1);
        check_evt("en_release_silent", 0, 0, 0);
        cyc(4'b0001, 1'b1, 1'b1);
        check_evt("en_fresh_press", 1, 0, 0);
        cyc(4'b0000, 1'b1, 1'b1);
        cyc(4'b0000, 1'b1, 1'b1);

        // reset in RPT with key held, ack low so an event is pending
        repeat (LONG_N + 3) cyc(4'b0001, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_evt("rst_async", 0, 0, 0);
        check_lit("rst_async_drop", int'(oDrop), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc(4'b0001, 1'b1, 1'b1);
        check_evt("rst_held_silent", 0, 0, 0);
        cyc(4'b0000, 1'b1, 1'b1);
        cyc(4'b0001, 1'b1, 1'b1);
        check_evt("rst_new_press", 1, 0, 0);
        cyc(4'b0000, 1'b1, 1'b1);

        // random traffic checked by the model every cycle
        b_cur = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0)
                b_cur = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc(b_cur, ($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
